// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, frame constants and parity helper for the PS/2 device
package ps2_pkg;
  typedef enum logic [3:0] {
    IDLE, TX_HI, TX_LO, TX_END, RX_REL, RX_LO, RX_HI, ACK_LO, ACK_HI
  } ps2_state_t;
  localparam int FRAME_BITS = 11;
  localparam logic OC_LOW = 1'b0;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronizer for the PS/2 clock and data lines, idling high
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_c,
  input  logic i_d,
  output logic o_c,
  output logic o_d
);
  logic [1:0] r_c, r_d;
  // shift both lines through two flops; reset to the released (high) bus level
  always_ff @(posedge clk)
    if (reset) begin
      r_c <= 2'b11;
      r_d <= 2'b11;
    end else begin
      r_c <= {r_c[0], i_c};
      r_d <= {r_d[0], i_d};
    end
  assign o_c = r_c[1];
  assign o_d = r_d[1];
endmodule

// File: rtl/ps2_dev.sv
// ps2_dev: PS/2 device-side transceiver generating the bus clock for both directions
module ps2_dev
  import ps2_pkg::*;
#(
  parameter int CLK_HALF = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_dev,
  input  logic [7:0] din,
  inout  wire        ps2d,
  inout  wire        ps2c,
  output logic       busy,
  output logic       tx_done_tick,
  output logic       rx_done_tick,
  output logic       rx_err,
  output logic [7:0] dout
);
  localparam int CW = $clog2(CLK_HALF);
  ps2_state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_bit, w_bit_n;
  logic [FRAME_BITS-1:0] r_frame;
  logic [9:0] r_shift;
  logic [7:0] r_dout;
  logic r_pend, r_tx_done, r_rx_done, r_rx_err;
  logic w_cs, w_ds, w_last, w_settled, w_c_low, w_d_low, w_tx_done, w_rx_done, w_rx_err;
  ps2_line_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .i_c  (ps2c),
    .i_d  (ps2d),
    .o_c  (w_cs),
    .o_d  (w_ds)
  );
  assign w_last    = r_cnt == CW'(CLK_HALF - 1);
  // our own ps2d release needs the synchronizer to catch up before IDLE trusts the bus
  assign w_settled = r_cnt == CW'(3);
  assign busy      = (r_state != IDLE) || r_pend;
  assign ps2c      = w_c_low ? OC_LOW : 1'bz;
  assign ps2d      = w_d_low ? OC_LOW : 1'bz;
  assign tx_done_tick = r_tx_done;
  assign rx_done_tick = r_rx_done;
  assign rx_err       = r_rx_err;
  assign dout         = r_dout;
  // state and bit counter registers
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_n;
      r_bit   <= w_bit_n;
    end
  // half-period timer: restarts on every state change, saturates in IDLE as a settle guard
  always_ff @(posedge clk)
    if (reset || w_state_n != r_state) r_cnt <= '0;
    else if (r_state != IDLE || !w_settled) r_cnt <= r_cnt + 1'b1;
  // next state, line drives and completion pulses
  always_comb begin
    w_state_n = r_state;
    w_bit_n   = r_bit;
    w_c_low   = 1'b0;
    w_d_low   = 1'b0;
    w_tx_done = 1'b0;
    w_rx_done = 1'b0;
    w_rx_err  = 1'b0;
    case (r_state)
      IDLE:
        if (w_settled && w_cs && !w_ds) w_state_n = RX_REL;
        else if (w_settled && r_pend && w_cs && w_ds) begin
          w_state_n = TX_HI;
          w_bit_n   = '0;
        end
      TX_HI: begin
        w_d_low = ~r_frame[r_bit];
        if (w_last) w_state_n = w_cs ? TX_LO : IDLE;
      end
      TX_LO: begin
        w_d_low = ~r_frame[r_bit];
        w_c_low = 1'b1;
        if (w_last) begin
          w_state_n = (r_bit == 4'd10) ? TX_END : TX_HI;
          w_bit_n   = r_bit + 1'b1;
        end
      end
      TX_END:
        if (w_last) begin
          w_state_n = IDLE;
          w_tx_done = 1'b1;
        end
      RX_REL:
        if (w_last) begin
          w_state_n = RX_LO;
          w_bit_n   = '0;
        end
      RX_LO: begin
        w_c_low = 1'b1;
        if (w_last) w_state_n = RX_HI;
      end
      RX_HI:
        if (w_last) begin
          w_bit_n   = r_bit + 1'b1;
          w_state_n = (r_bit != 4'd9) ? RX_LO : r_shift[9] ? ACK_LO : IDLE;
          w_rx_err  = (r_bit == 4'd9) && !r_shift[9];
        end
      ACK_LO: begin
        w_c_low = 1'b1;
        w_d_low = 1'b1;
        if (w_last) w_state_n = ACK_HI;
      end
      ACK_HI: begin
        w_d_low = 1'b1;
        if (w_last) begin
          w_state_n = IDLE;
          w_rx_done = ^r_shift[8:0];
          w_rx_err  = ~^r_shift[8:0];
        end
      end
      default: w_state_n = IDLE;
    endcase
  end
  // datapath: pending frame, receive shifter, received byte and registered ticks
  always_ff @(posedge clk)
    if (reset) begin
      r_pend    <= 1'b0;
      r_frame   <= '1;
      r_shift   <= '0;
      r_dout    <= '0;
      r_tx_done <= 1'b0;
      r_rx_done <= 1'b0;
      r_rx_err  <= 1'b0;
    end else begin
      r_tx_done <= w_tx_done;
      r_rx_done <= w_rx_done;
      r_rx_err  <= w_rx_err;
      if (r_state == RX_LO && w_last) r_shift[r_bit] <= w_ds;
      if (w_rx_done) r_dout <= r_shift[7:0];
      if (w_tx_done) r_pend <= 1'b0;
      else if (wr_dev && !busy) begin
        r_pend  <= 1'b1;
        r_frame <= {1'b1, odd_parity(din), din, 1'b0};
      end
    end
endmodule

// File: doc/ps2_dev.md
Name: ps2_dev

Overview:
PS/2 device-side (keyboard/mouse end) transceiver: the counterpart of the team's host-side PS/2 rx/tx pair.
- Generates the PS/2 clock and sends device-to-host frames.
- Detects host request-to-send, clocks in host-to-device commands and acknowledges them.
- Used for board-to-board links and as a synthesizable bus-functional device model in host testbenches.

Parameters:
CLK_HALF, 2000, system clocks per PS/2 clock half period (2000 = 40 us at 50 MHz, i.e. 12.5 kHz); minimum 4.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_dev  in  1  request to send din to host; accepted only when busy=0
din  in  8  byte to send
ps2d  inout  1  PS/2 data, open-collector: driven 0 or z only
ps2c  inout  1  PS/2 clock, open-collector: driven 0 or z only
busy  out  1  high while not idle or a transmit is pending
tx_done_tick  out  1  one-cycle pulse when a device-to-host frame completes
rx_done_tick  out  1  one-cycle pulse when a valid host byte is on dout
rx_err  out  1  one-cycle pulse on host frame parity or stop error
dout  out  8  last host byte received, held until the next valid byte

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset); ps2c/ps2d inputs pass a 2-flop synchronizer (cs, ds) before use.
- Reset: both lines released (z), state IDLE, pending=0, busy=0, all ticks 0, dout=8'h00. Reset asserted mid-frame releases both lines on the next clk edge; the frame is discarded with no tick.
- Frame, both directions: start 0, 8 data bits LSB first, odd parity, stop 1. One half-period counter counts 0..CLK_HALF-1; one 4-bit bit counter.
- wr_dev with busy=0: latch frame {1, ~^din, din, 0}, set pending=1. wr_dev while busy=1 is ignored.
- States: IDLE, TX_HI, TX_LO, TX_END, RX_REL, RX_LO, RX_HI, ACK_LO, ACK_HI.
- IDLE priority 1 (host RTS): cs=1 && ds=0 -> RX_REL. This wins over a pending transmit.
- IDLE priority 2: pending && cs=1 && ds=1 -> TX_HI, bit=0. While host inhibits (cs=0), pending waits.
- TX_HI: drive ps2d = frame[bit] (0 -> drive low, 1 -> z), release clock, hold CLK_HALF cycles.
  - At the last cycle, if cs=0 (host inhibit): release both lines, go to IDLE, keep pending=1. Retransmission restarts from the start bit.
  - Otherwise -> TX_LO.
- TX_LO: keep data, drive ps2c low for CLK_HALF cycles; bit++. After bit 10 -> TX_END, else -> TX_HI.
- TX_END: release both lines for CLK_HALF cycles; pulse tx_done_tick, clear pending, go to IDLE.
- RX_REL: wait CLK_HALF with lines released -> RX_LO, bit=0.
- RX_LO: drive ps2c low CLK_HALF cycles; at its last cycle sample ds into shift[bit] (rising-edge sample) -> RX_HI.
- RX_HI: release clock CLK_HALF cycles; bit++. After 10 samples (8 data, parity, stop) evaluate:
  - stop=0: pulse rx_err, no ack, go to IDLE.
  - else -> ACK_LO.
- ACK_LO: drive ps2d low and ps2c low, CLK_HALF cycles.
- ACK_HI: ps2c released, ps2d still low, CLK_HALF cycles; then release ps2d.
  - Parity odd: load dout, pulse rx_done_tick.
  - Else: pulse rx_err.
  - Go to IDLE.
- Frame latencies from IDLE exit:
  - Transmit: 23*CLK_HALF cycles to tx_done_tick.
  - Receive: 23*CLK_HALF cycles to rx_done_tick.
- Host releasing ps2d early or late during receive is not checked beyond the parity and stop checks.
- Ticks are registered and never overlap.

Decomposition:
- Package ps2_pkg:
  - state enum
  - FRAME_BITS=11
  - odd_parity(byte) function
  - drive-low/release constant for open-collector outputs
- One sub-module, ps2_line_sync: 2-flop synchronizer for ps2c/ps2d, reset to 1 (idle bus).

Test Plan:
1. CLK_HALF=4, bench host model (pull-ups, samples ps2d on ps2c falls), wr_dev with din=8'h1C -> bits 0,0,0,1,1,1,0,0,0,0,1 captured; exactly one tx_done_tick 92 cycles after TX_HI entry; busy low after.
2. Host RTS (ps2c low 100 cycles, then ds=0 and release), sends 8'hFF with parity 1 -> device drives ps2d low during ACK phases; dout=8'hFF; one rx_done_tick; rx_err=0.
3. Host sends 8'hED with parity 0 (wrong) -> ack still driven; rx_err pulses once; no rx_done_tick; dout holds previous 8'hFF.
4. wr_dev din=8'hA5; host holds ps2c low across the bit-4 high phase for 50 cycles -> both lines released within 3 cycles; busy stays 1; full frame retransmitted from start bit after release; exactly one tx_done_tick.
5. wr_dev din=8'h12 in the same cycle host RTS is visible -> receive completes first (rx_done_tick), then 8'h12 frame is sent (tx_done_tick).
6. reset asserted during RX_LO of bit 3 -> next cycle ps2c/ps2d are z, busy=0, dout=8'h00, no ticks; a fresh RTS afterwards is received correctly.
